fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS32 single-issue core, directly upstream of `controlunit`. It owns the program counter, runs the instruction-memory request/ready handshake, and presents the fetched word and its opcode to the decoder. It also computes the next PC from `controlunit`'s `branch`/`bne`/`jump` outputs and the ALU `zero` flag. It halts on any opcode the decoder does not support.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset. Must be word aligned.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: word-aligned fetch address. Equals `pc` whenever `imem_req`=1.
- `imem_rdata` in 32: instruction word. Sampled only in the cycle `imem_ready`=1.
- `imem_ready` in 1: memory data-valid strobe. Zero or more wait cycles after the request.
- `stall` in 1: downstream not ready. Holds the current instruction.
- `branch`, `bne`, `jump` in 1 each: from `controlunit` for the held instruction.
- `zero` in 1: ALU equality flag for the held instruction.
- `inst` out 32: held instruction word.
- `opcode` out 6: `inst[31:26]`, which feeds `controlunit`.
- `inst_valid` out 1: `inst`/`opcode`/`pc` are valid.
- `pc` out 32: address of `inst`.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32.
- `illegal_op` out 1: sticky flag set when an unsupported opcode is fetched.
- `retired` out 32: count of instructions released downstream. Wraps at 2^32.

## Operation
- The FSM has four states: IDLE, FETCH, HOLD and HALT.
- **IDLE**: the reset state. Moves unconditionally to FETCH on the next edge.
- **FETCH**:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready`=1.
  - On `imem_ready`=1, register `inst`<=`imem_rdata`, then go to HOLD if the opcode is supported, otherwise to HALT.
- **Supported opcodes**: 0, 2, 4, 5, 35, 43. Any other opcode is illegal.
- **HOLD**:
  - `inst_valid`=1 and `imem_req`=0.
  - If `stall`=1: stay in HOLD, all outputs frozen.
  - If `stall`=0: `pc`<=`next_pc`, `retired`<=`retired`+1, go to FETCH.
- **HALT**:
  - `illegal_op`=1, `inst_valid`=0, `imem_req`=0.
  - `pc` and `inst` keep the offending address and word.
  - Only `rst` exits HALT.
- **next_pc** (priority order):
  1. If `jump`=1: `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  2. Else if (`branch` & `zero`) | (`bne` & ~`zero`): `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`, 32-bit, wrap modulo 2^32.
  3. Else: `pc_plus4`.
- `branch`/`bne`/`jump`/`zero` are sampled only in HOLD with `stall`=0 and are ignored in every other state. X on these inputs outside that window must not propagate into state.
- `imem_ready` outside FETCH is ignored. This covers late responses after reset or redirect.

## Timing
- **Reset values**:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`
  - `inst`=0, `opcode`=0
  - `inst_valid`=0, `imem_req`=0, `illegal_op`=0, `retired`=0
  - state IDLE
- First `imem_req`=1 appears in the first cycle after `rst` deasserts (IDLE, then FETCH).
- **Zero-wait memory**: `imem_ready`=1 in the first FETCH cycle; `inst_valid`=1 in the next cycle.
- **Per-instruction throughput**: 2 cycles minimum (FETCH, HOLD) plus memory wait cycles plus stall cycles.
- `inst_valid` falls in the cycle after the HOLD exit. `pc` updates on the same edge.
- `illegal_op` rises in the cycle after the illegal word is accepted. `inst_valid` never asserts for that word.
- `rst`=1 in any state, including mid-FETCH with `imem_ready` arriving in the same cycle: reset wins, the word is discarded, and all outputs take reset values on that edge.
- `stall` in FETCH has no effect. The fetch completes and the FSM waits in HOLD.

## Test plan
- **Reset and first fetch**: reset, then zero-wait memory returns 32'h8C08_0004 (lw) -> `imem_addr`=32'h0040_0000, `inst_valid`=1 one cycle after ready, `opcode`=35.
- **Sequential flow with wait states**: R-type at 0x400000 with `imem_ready` delayed 3 cycles -> `imem_req`/`imem_addr` stable for 4 cycles, next fetch at 0x400004, `retired`=1.
- **beq taken**:
  - `inst`=32'h1000_FFFF, `branch`=1, `zero`=1 at pc 0x400008 -> next fetch at 0x400008.
  - Same instruction with `zero`=0 -> next fetch at 0x40000C.
- **bne and jump**:
  - `bne`=1, `zero`=0, imm 16'h0003 at 0x400010 -> next fetch at 0x400020.
  - `jump`=1, `inst`=32'h0810_0000 -> next fetch at 0x0040_0000. `jump` wins when `branch` is also 1.
- **Stall and illegal op**:
  - `stall`=1 for 5 cycles in HOLD -> `inst`, `pc` and `retired` unchanged, and branch inputs toggling during the stall have no effect.
  - Fetch 32'hFC00_0000 -> `illegal_op`=1, `imem_req` stays 0, and `retired` is frozen until `rst`.
- **Reset mid-fetch**: `rst` asserted in the same cycle as `imem_ready`=1 -> `inst`=0, `pc`=`RESET_PC`, and the refetch starts 1 cycle after `rst` deasserts.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS32 instruction-fetch stage owning the PC, the imem handshake
// and next-PC selection from the decoder's branch/jump outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] inst,
   output logic [5:0]  opcode,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        illegal_op,
   output logic [31:0] retired
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
   state_t state, state_next;
   logic [31:0] next_pc;
   logic [5:0]  rop;
   logic        legal, accept, advance, take;

   assign rop     = imem_rdata[31:26];
   assign legal   = rop inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd35, 6'd43};
   assign accept  = (state == FETCH) && imem_ready;
   assign advance = (state == HOLD) && !stall;
   assign take    = (branch & zero) | (bne & ~zero);
   assign next_pc = jump ? {pc_plus4[31:28], inst[25:0], 2'b00}
                  : take ? pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}
                  : pc_plus4;

   assign pc_plus4   = pc + 32'd4;
   assign opcode     = inst[31:26];
   assign imem_req   = state == FETCH;
   assign imem_addr  = pc;
   assign inst_valid = state == HOLD;
   assign illegal_op = state == HALT;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = FETCH;
         FETCH:   state_next = imem_ready ? (legal ? HOLD : HALT) : FETCH;
         HOLD:    state_next = stall ? HOLD : FETCH;
         default: state_next = HALT;
      endcase
   end

   // Control inputs only reach state through the advance-gated pc update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         inst    <= '0;
         retired <= '0;
      end else begin
         state <= state_next;
         if (accept) inst <= imem_rdata;
         if (advance) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst, imem_ready, stall, branch, bne, jump, zero;
   logic [31:0] imem_rdata;
   logic        imem_req, inst_valid, illegal_op;
   logic [31:0] imem_addr, inst, pc, pc_plus4, retired;
   logic [5:0]  opcode;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_inst_q[$];
   logic [31:0] cur_addr;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
      .branch(branch), .bne(bne), .jump(jump), .zero(zero),
      .inst(inst), .opcode(opcode), .inst_valid(inst_valid), .pc(pc),
      .pc_plus4(pc_plus4), .illegal_op(illegal_op), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue the expected address/word, serve the request after 'waits' idle cycles.
   task automatic do_fetch(input logic [31:0] word, input int waits, input logic [31:0] addr,
                           input logic legal, input logic stall_in_fetch);
      int n = 0;
      exp_addr_q.push_back(addr);
      if (legal) exp_inst_q.push_back(word);
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
      cur_addr = exp_addr_q.pop_front();
      chk("imem_addr", imem_addr, cur_addr);
      stall = stall_in_fetch;
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         tick();
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_held", imem_addr, cur_addr);
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      if (legal) begin
         chk("inst_valid", {31'd0, inst_valid}, 32'd1);
         chk("req_low_hold", {31'd0, imem_req}, 32'd0);
         chk("inst", inst, exp_inst_q.pop_front());
         chk("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
         chk("pc", pc, cur_addr);
         chk("pc_plus4", pc_plus4, cur_addr + 32'd4);
      end
   endtask

   task automatic release_hold(input logic b, input logic n, input logic j, input logic z);
      stall = 1'b0;
      branch = b; bne = n; jump = j; zero = z;
      tick();
      exp_ret++;
      branch = 1'bx; bne = 1'bx; jump = 1'bx; zero = 1'bx;
      chk("valid_fall", {31'd0, inst_valid}, 32'd0);
      chk("retired", retired, exp_ret);
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; imem_rdata = '0;
      branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
      tick();
      tick();
      chk("rst_pc", pc, 32'h0040_0000);
      chk("rst_pc4", pc_plus4, 32'h0040_0004);
      chk("rst_inst", inst, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'd0);
      chk("rst_flags", {28'd0, inst_valid, imem_req, illegal_op, 1'b0}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      rst = 1'b0;
      tick();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      do_fetch(32'h8C08_0004, 0, 32'h0040_0000, 1'b1, 1'b0);
      release_hold(1'b0, 1'b0, 1'b0, 1'b0);
      do_fetch(32'h0109_5020, 3, 32'h0040_0004, 1'b1, 1'b1);
      release_hold(1'b0, 1'b0, 1'b0, 1'b0);
      do_fetch(32'h1000_FFFF, 0, 32'h0040_0008, 1'b1, 1'b0);
      release_hold(1'b1, 1'b0, 1'b0, 1'b1);
      do_fetch(32'h1000_FFFF, 1, 32'h0040_0008, 1'b1, 1'b0);
      release_hold(1'b1, 1'b0, 1'b0, 1'b0);
      do_fetch(32'h0000_0020, 0, 32'h0040_000C, 1'b1, 1'b0);
      release_hold(1'b0, 1'b0, 1'b0, 1'b0);
      do_fetch(32'h1400_0003, 2, 32'h0040_0010, 1'b1, 1'b0);
      release_hold(1'b0, 1'b1, 1'b0, 1'b0);
      do_fetch(32'h0810_0000, 0, 32'h0040_0020, 1'b1, 1'b0);
      release_hold(1'b1, 1'b0, 1'b1, 1'b1);
      do_fetch(32'h8C08_0004, 0, 32'h0040_0000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         stall = 1'b1;
         branch = i[0]; bne = ~i[0]; jump = i[1]; zero = i[0];
         imem_ready = 1'b1;
         imem_rdata = 32'hFC00_0000;
         tick();
         chk("stall_valid", {31'd0, inst_valid}, 32'd1);
         chk("stall_inst", inst, 32'h8C08_0004);
         chk("stall_pc", pc, 32'h0040_0000);
         chk("stall_retired", retired, exp_ret);
      end
      imem_ready = 1'b0;
      release_hold(1'b0, 1'b0, 1'b0, 1'b0);
      do_fetch(32'hFC00_0000, 0, 32'h0040_0004, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         imem_ready = i[0];
         stall = i[1];
         tick();
         chk("halt_illegal", {31'd0, illegal_op}, 32'd1);
         chk("halt_valid", {31'd0, inst_valid}, 32'd0);
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_pc", pc, 32'h0040_0004);
         chk("halt_inst", inst, 32'hFC00_0000);
         chk("halt_retired", retired, exp_ret);
      end
      imem_ready = 1'b0; stall = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst2_illegal", {31'd0, illegal_op}, 32'd0);
      rst = 1'b0;
      exp_ret = 0;
      tick();
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      imem_rdata = 32'h8C08_0004;
      rst = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("midrst_inst", inst, 32'd0);
      chk("midrst_pc", pc, 32'h0040_0000);
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
      chk("midrst_retired", retired, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0040_0000);
      do_fetch(32'h0000_0020, 0, 32'h0040_0000, 1'b1, 1'b0);
      release_hold(1'b0, 1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
